mul_seq6801: RTL and testbench

Multi-cycle sequencer for the 6801 `MUL` instruction: computes ACCD = ACCA × ACCB with a shift-and-add loop, one multiplier bit per clock. It sits beside the 8/16-bit ALU and the CC register in the CPU core. The CPU control FSM starts it, stalls on `busy`, and loads the product into ACCD and the condition code into CC when `done` pulses. Timing matches the 6801 MUL cycle count, with the CPU's own fetch/decode cycle making up the remainder.

---
 rtl/mul_seq6801_pkg.sv | 32 +++
 rtl/mul_seq6801_step.sv | 17 +
 rtl/mul_seq6801.sv | 99 +++++++++
 tb/tb_mul_seq6801.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mul_seq6801_pkg.sv
// Shared CPU package slice: CC bit indices, MUL sequencer state type and helpers.
// Used by mul_seq6801 (optional feature macro: MUL_ZERO_SKIP_EN).
package mul_seq6801_pkg;

  // 6801 condition-code bit positions (bits 7:6 read as 1 on real silicon).
  localparam int CBIT = 0;
  localparam int VBIT = 1;
  localparam int ZBIT = 2;
  localparam int NBIT = 3;
  localparam int IBIT = 4;
  localparam int HBIT = 5;
  localparam int XBIT = 6;
  localparam int SBIT = 7;

  localparam int         MUL_ITERS    = 8;
  localparam logic [2:0] MUL_LAST_CNT = 3'(MUL_ITERS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  // MUL touches only C, which takes bit 7 of the product (the rounding bit of B).
  function automatic logic [7:0] cc_mul_update(input logic [7:0] cc, input logic c);
    logic [7:0] r;
    r       = cc;
    r[CBIT] = c;
    return r;
  endfunction

endpackage

// File: rtl/mul_seq6801_step.sv
// One shift-and-add step of the 6801 MUL: conditionally add mcand into hi,
// then shift the 17-bit {carry,hi,lo} right by one, keeping the low 16 bits.
module mul6801_step (
  input  logic [7:0]  hi,
  input  logic [7:0]  lo,
  input  logic [7:0]  mcand,
  output logic [15:0] nxt
);

  logic [8:0] sum;

  always_comb begin
    sum = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : 9'd0);
    nxt = {sum, lo[7:1]};
  end

endmodule

// File: rtl/mul_seq6801.sv
// Multi-cycle 6801 MUL sequencer: ACCD = ACCA * ACCB, one multiplier bit per clock.
// Optional MUL_ZERO_SKIP_EN: zero operand finishes immediately (not cycle-exact).
module mul_seq6801
  import mul_seq6801_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic        start,
  input  logic [7:0]  acca,
  input  logic [7:0]  accb,
  input  logic [7:0]  cc_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] prod,
  output logic [7:0]  cc_out,
  output logic        cc_load
);

  // Handshake: start is a one-cycle request honoured only in IDLE or in the
  // done cycle (hold low); done is a one-cycle pulse with prod/cc_out valid,
  // and busy covers every cycle from the accepting edge to the edge after done.

  mul_state_t state;
  logic [7:0]  mcand;
  logic [7:0]  hi;
  logic [7:0]  lo;
  logic [2:0]  cnt;
  logic [15:0] step_nxt;
  logic        skip;

  mul6801_step u_step (
    .hi    (hi),
    .lo    (lo),
    .mcand (mcand),
    .nxt   (step_nxt)
  );

`ifdef MUL_ZERO_SKIP_EN
  assign skip = (acca == 8'h00) || (accb == 8'h00);
`else
  assign skip = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      mcand <= 8'h00;
      hi    <= 8'h00;
      lo    <= 8'h00;
      cnt   <= 3'd0;
      busy  <= 1'b0;
      done  <= 1'b0;
      prod  <= 16'h0000;
    end else if (!hold) begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            mcand <= acca;
            hi    <= 8'h00;
            lo    <= accb;
            cnt   <= 3'd0;
            busy  <= 1'b1;
            if (skip) begin
              state <= DONE;
              done  <= 1'b1;
              prod  <= 16'h0000;
            end else begin
              state <= ITER;
            end
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        ITER: begin
          {hi, lo} <= step_nxt;
          cnt      <= cnt + 3'd1;
          // The last step's result goes straight into prod so it is valid with done.
          if (cnt == MUL_LAST_CNT) begin
            state <= DONE;
            done  <= 1'b1;
            prod  <= step_nxt;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign cc_out  = cc_mul_update(cc_in, prod[7]);
  assign cc_load = done;

endmodule

// File: tb/tb_mul_seq6801.sv
// Bench for mul_seq6801: random and directed MUL operations, scoreboard of
// expected {done cycle, product} checked by an independent monitor.
module tb_mul_seq6801;

  logic        clk = 1'b0;
  logic        rst;
  logic        hold;
  logic        start;
  logic [7:0]  acca;
  logic [7:0]  accb;
  logic [7:0]  cc_in;
  logic        busy;
  logic        done;
  logic [15:0] prod;
  logic [7:0]  cc_out;
  logic        cc_load;

  int          tests = 0;
  int          fails = 0;
  int unsigned cyc = 0;
  logic        hold_at_edge = 1'b0;
  logic        prev_done = 1'b0;
  logic [31:0] exp_q[$];

  mul_seq6801 dut (
    .clk     (clk),
    .rst     (rst),
    .hold    (hold),
    .start   (start),
    .acca    (acca),
    .accb    (accb),
    .cc_in   (cc_in),
    .busy    (busy),
    .done    (done),
    .prod    (prod),
    .cc_out  (cc_out),
    .cc_load (cc_load)
  );

  // clock / reset block
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc          = cyc + 1;
    hold_at_edge = hold;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: edges from accept to done, and the product as plain arithmetic.
  function automatic int latency(input logic [7:0] a, input logic [7:0] b);
`ifdef MUL_ZERO_SKIP_EN
    if (a == 8'h00 || b == 8'h00) return 0;
`endif
    return 8;
  endfunction

  // driver tasks (called at a falling edge, return at a falling edge)
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                       input int k, input int l);
    int unsigned c0;
    logic [15:0] p;
    acca  = a;
    accb  = b;
    cc_in = c;
    start = 1'b1;
    @(posedge clk);
    #1;
    c0    = cyc;
    start = 1'b0;
    acca  = 8'($urandom);
    accb  = 8'($urandom);
    p     = 16'(a) * 16'(b);
    exp_q.push_back({16'(c0 + 32'(latency(a, b)) + 32'(l)), p});
    @(negedge clk);
    if (l > 0) begin
      repeat (k) @(negedge clk);
      hold = 1'b1;
      repeat (l) @(negedge clk);
      hold = 1'b0;
    end
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("done_timeout", 32'(ok), 32'd1);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [31:0] e;
    if (!rst) begin
      if (done && !(prev_done && hold_at_edge)) begin
        check("cc_load", 32'(cc_load), 32'd1);
        check("busy_at_done", 32'(busy), 32'd1);
        if (exp_q.size() == 0) begin
          check("unexpected_done_qsize", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("prod", 32'(prod), 32'(e[15:0]));
          check("done_cycle", 32'(16'(cyc)), 32'(e[31:16]));
          check("cc_out", 32'(cc_out), 32'((cc_in & 8'hFE) | {7'b0, e[7]}));
        end
      end
    end
    prev_done = done;
  end

  initial begin
    logic [7:0] a;
    logic [7:0] b;
    int         k;
    int         l;
    rst   = 1'b1;
    hold  = 1'b0;
    start = 1'b0;
    acca  = 8'h00;
    accb  = 8'h00;
    cc_in = 8'hC0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_cc_load", 32'(cc_load), 32'd0);
    check("rst_prod", 32'(prod), 32'h0000);
    check("rst_cc_out", 32'(cc_out), 32'(cc_in));
    rst = 1'b0;
    @(negedge clk);

    issue(8'hFF, 8'hFF, 8'hC1, 0, 0);
    wait_done();
    check("ff_ff_cc_out", 32'(cc_out), 32'h00C0);
    @(negedge clk);
    issue(8'h0C, 8'h0B, 8'hC0, 0, 0);
    wait_done();
    check("0c_0b_cc_out", 32'(cc_out), 32'h00C1);
    @(negedge clk);

    // hold mid-iteration, then hold across the done cycle
    issue(8'h12, 8'h34, 8'hC5, 2, 3);
    wait_done();
    hold = 1'b1;
    @(negedge clk);
    check("hold_done_kept", 32'(done), 32'd1);
    check("hold_prod_kept", 32'(prod), 32'h03A8);
    @(negedge clk);
    check("hold_done_kept2", 32'(done), 32'd1);
    hold = 1'b0;
    @(negedge clk);
    check("hold_release_done", 32'(done), 32'd0);
    check("hold_release_busy", 32'(busy), 32'd0);

    // start during ITER ignored, then back-to-back start in the done cycle
    issue(8'h25, 8'h4D, 8'h00, 0, 0);
    repeat (2) @(negedge clk);
    acca  = 8'h99;
    accb  = 8'h77;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    issue(8'h07, 8'h09, 8'hFF, 0, 0);
    wait_done();
    @(negedge clk);

    issue(8'h00, 8'h37, 8'hFF, 0, 0);
    wait_done();
    check("zero_c_bit", 32'(cc_out[0]), 32'd0);
    @(negedge clk);
    issue(8'h5A, 8'h00, 8'h01, 0, 0);
    wait_done();
    @(negedge clk);

    // reset in the middle of an operation
    issue(8'hAB, 8'hCD, 8'h00, 0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_prod", 32'(prod), 32'h0000);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("midrst_no_done", 32'(done), 32'd0);
    issue(8'h80, 8'h03, 8'h2A, 0, 0);
    wait_done();
    @(negedge clk);

    // randomized operations, random holds, random back-to-back
    for (int n = 0; n < 40; n++) begin
      a = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      k = $urandom_range(0, 4);
      l = (a == 8'h00 || b == 8'h00) ? 0 : $urandom_range(0, 3);
      issue(a, b, 8'($urandom), k, l);
      wait_done();
      if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (12) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
